// File: rtl/stage_execute_if.sv
// ---------------------------------------------------------------------------
// stage_execute_if
//
// Bundles every non-clock, non-reset signal of the bfcpu2 execute/writeback
// stage: the operation handshake from data-fetch, the data RAM write port,
// and the character output/input handshakes.
//
// Modports
//   master : environment side (data-fetch, RAM, console). Drives the
//            operation, its operands, cout_ack, cin and cin_valid.
//   slave  : the execute stage. Drives ack, the RAM write port, cout,
//            cout_valid, cin_ack and the branch outputs.
//
// Handshake rules, stated once:
//   - An operation transfers on a rising edge where drdy_in && ack. While
//     ack is 0 upstream holds operation_in/a_in/da_in stable.
//   - A character leaves on a rising edge where cout_valid && cout_ack.
//   - cin is taken on the edge after which cin_ack pulses for one cycle.
//   - dwe, branch and cin_ack are single-cycle pulses; dwa/dwd and
//     branch_taken are meaningful only while their qualifier is 1.
//
// Opcode bit positions of the one-hot operation bus are defined below and
// shared with the stage.
// ---------------------------------------------------------------------------
`ifndef OPCODE_MSB
`define OPCODE_MSB   7
`endif
`ifndef OP_INCDP
`define OP_INCDP     0
`define OP_DECDP     1
`define OP_INC       2
`define OP_DEC       3
`define OP_OUT       4
`define OP_IN        5
`define OP_LOOPBEGIN 6
`define OP_LOOPEND   7
`endif

interface stage_execute_if #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
);
  logic [`OPCODE_MSB:0] operation_in;
  logic                 drdy_in;
  logic [D_WIDTH-1:0]   a_in;
  logic [A_WIDTH-1:0]   da_in;
  logic                 ack;
  logic                 dwe;
  logic [A_WIDTH-1:0]   dwa;
  logic [D_WIDTH-1:0]   dwd;
  logic [D_WIDTH-1:0]   cout;
  logic                 cout_valid;
  logic                 cout_ack;
  logic [D_WIDTH-1:0]   cin;
  logic                 cin_valid;
  logic                 cin_ack;
  logic                 branch;
  logic                 branch_taken;

  modport master (
    output operation_in, drdy_in, a_in, da_in, cout_ack, cin, cin_valid,
    input  ack, dwe, dwa, dwd, cout, cout_valid, cin_ack, branch, branch_taken
  );

  modport slave (
    input  operation_in, drdy_in, a_in, da_in, cout_ack, cin, cin_valid,
    output ack, dwe, dwa, dwd, cout, cout_valid, cin_ack, branch, branch_taken
  );
endinterface

// File: rtl/stage_execute.sv
// ---------------------------------------------------------------------------
// stage_execute
//
// Execute/writeback stage of the bfcpu2 pipeline. Takes the one-hot
// operation and the fetched cell value from data-fetch and performs:
//   INC/DEC    : write operand +/- 1 (wrapping) back to data RAM
//   LOOPBEGIN  : branch pulse, taken when operand == 0
//   LOOPEND    : branch pulse, taken when operand != 0
//   OUT        : present operand on cout
//   IN         : wait for cin, then write it to the cell
//   INCDP/DECDP/none : accepted, no effect here
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low
//   bus       : stage_execute_if.slave (operation handshake, RAM write port,
//               console handshakes)
//   state_dbg : current FSM state, for observation only
//
// A two-entry write history (newest first) supplies the operand when the
// fetched address matches a recent write, so back-to-back and one-gap
// read-after-write sequences see fresh data even though RAM lags.
//
// Build option: define STAGE_EXECUTE_OUT_FIFO_EN to buffer OUT characters
// in a 4-entry FIFO instead of stalling in WAIT_OUT on every OUT.
// ---------------------------------------------------------------------------
`ifndef OPCODE_MSB
`define OPCODE_MSB   7
`endif
`ifndef OP_INCDP
`define OP_INCDP     0
`define OP_DECDP     1
`define OP_INC       2
`define OP_DEC       3
`define OP_OUT       4
`define OP_IN        5
`define OP_LOOPBEGIN 6
`define OP_LOOPEND   7
`endif

module stage_execute #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  stage_execute_if.slave      bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_WAIT_OUT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OPK_NONE  = 3'd0,
    OPK_INC   = 3'd1,
    OPK_DEC   = 3'd2,
    OPK_OUT   = 3'd3,
    OPK_IN    = 3'd4,
    OPK_LOOPB = 3'd5,
    OPK_LOOPE = 3'd6
  } op_kind_t;

  state_t   state_q, state_d;
  op_kind_t op_kind;

  logic                ack_c;
  logic                accept;
  logic [D_WIDTH-1:0]  operand;

  // Registered outputs
  logic                dwe_q, dwe_d;
  logic [A_WIDTH-1:0]  dwa_q, dwa_d;
  logic [D_WIDTH-1:0]  dwd_q, dwd_d;
  logic [D_WIDTH-1:0]  cout_q, cout_d;
  logic                cout_valid_q, cout_valid_d;
  logic                cin_ack_q, cin_ack_d;
  logic                branch_q, branch_d;
  logic                branch_taken_q, branch_taken_d;

  // Target cell of a pending IN
  logic [A_WIDTH-1:0]  in_addr_q, in_addr_d;

  // Write history: entry 0 is the newest write, entry 1 the one before
  logic                byp0_valid_q, byp0_valid_d;
  logic [A_WIDTH-1:0]  byp0_addr_q, byp0_addr_d;
  logic [D_WIDTH-1:0]  byp0_data_q, byp0_data_d;
  logic                byp1_valid_q, byp1_valid_d;
  logic [A_WIDTH-1:0]  byp1_addr_q, byp1_addr_d;
  logic [D_WIDTH-1:0]  byp1_data_q, byp1_data_d;

`ifdef STAGE_EXECUTE_OUT_FIFO_EN
  logic [D_WIDTH-1:0]  fifo_mem_q [4];
  logic [D_WIDTH-1:0]  fifo_mem_d [4];
  logic [1:0]          fifo_rd_q, fifo_rd_d;
  logic [1:0]          fifo_wr_q, fifo_wr_d;
  logic [2:0]          fifo_cnt_q, fifo_cnt_d;
  logic                fifo_full;
  logic                fifo_push;
  logic                fifo_pop;
  logic [D_WIDTH-1:0]  fifo_head_d;
  logic                fifo_nonempty_d;
`endif

  // -------------------------------------------------------------------------
  // Opcode decode. Lowest set bit wins if upstream ever sends more than one.
  // -------------------------------------------------------------------------
  always_comb begin
    op_kind = OPK_NONE;
    case (1'b1)
      bus.operation_in[`OP_INCDP]:     op_kind = OPK_NONE;
      bus.operation_in[`OP_DECDP]:     op_kind = OPK_NONE;
      bus.operation_in[`OP_INC]:       op_kind = OPK_INC;
      bus.operation_in[`OP_DEC]:       op_kind = OPK_DEC;
      bus.operation_in[`OP_OUT]:       op_kind = OPK_OUT;
      bus.operation_in[`OP_IN]:        op_kind = OPK_IN;
      bus.operation_in[`OP_LOOPBEGIN]: op_kind = OPK_LOOPB;
      bus.operation_in[`OP_LOOPEND]:   op_kind = OPK_LOOPE;
      default:                         op_kind = OPK_NONE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand select: newest matching history entry, else the fetched value
  // -------------------------------------------------------------------------
  always_comb begin
    operand = bus.a_in;
    if (byp0_valid_q && (byp0_addr_q == bus.da_in)) begin
      operand = byp0_data_q;
    end else if (byp1_valid_q && (byp1_addr_q == bus.da_in)) begin
      operand = byp1_data_q;
    end
  end

`ifdef STAGE_EXECUTE_OUT_FIFO_EN
  // -------------------------------------------------------------------------
  // Output FIFO. The next head is computed here so cout/cout_valid can be
  // registered like every other output.
  // -------------------------------------------------------------------------
  assign fifo_full = (fifo_cnt_q == 3'd4);
  assign fifo_pop  = cout_valid_q && bus.cout_ack;
  assign fifo_push = accept && (op_kind == OPK_OUT);

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (fifo_push) begin
      fifo_mem_d[fifo_wr_q] = operand;
    end
    fifo_wr_d       = fifo_wr_q + {1'b0, fifo_push};
    fifo_rd_d       = fifo_rd_q + {1'b0, fifo_pop};
    fifo_cnt_d      = fifo_cnt_q + {2'b00, fifo_push} - {2'b00, fifo_pop};
    fifo_head_d     = fifo_mem_d[fifo_rd_d];
    fifo_nonempty_d = (fifo_cnt_d != 3'd0);
  end
`endif

  // -------------------------------------------------------------------------
  // ack: only RUN accepts. With the FIFO, an OUT facing a full FIFO is held
  // off unless the head leaves in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    ack_c = 1'b0;
    if (reset && (state_q == ST_RUN)) begin
      ack_c = 1'b1;
`ifdef STAGE_EXECUTE_OUT_FIFO_EN
      if (bus.drdy_in && (op_kind == OPK_OUT) && fifo_full && !fifo_pop) begin
        ack_c = 1'b0;
      end
`endif
    end
  end

  assign accept = bus.drdy_in && ack_c;

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    dwe_d          = 1'b0;
    dwa_d          = '0;
    dwd_d          = '0;
    cin_ack_d      = 1'b0;
    branch_d       = 1'b0;
    branch_taken_d = 1'b0;
    cout_d         = cout_q;
    cout_valid_d   = cout_valid_q;
    in_addr_d      = in_addr_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          case (op_kind)
            OPK_INC: begin
              dwe_d = 1'b1;
              dwa_d = bus.da_in;
              dwd_d = operand + D_WIDTH'(1);
            end
            OPK_DEC: begin
              dwe_d = 1'b1;
              dwa_d = bus.da_in;
              dwd_d = operand - D_WIDTH'(1);
            end
            OPK_LOOPB: begin
              branch_d       = 1'b1;
              branch_taken_d = (operand == '0);
            end
            OPK_LOOPE: begin
              branch_d       = 1'b1;
              branch_taken_d = (operand != '0);
            end
            OPK_IN: begin
              in_addr_d = bus.da_in;
              state_d   = ST_WAIT_IN;
            end
            OPK_OUT: begin
`ifndef STAGE_EXECUTE_OUT_FIFO_EN
              cout_d       = operand;
              cout_valid_d = 1'b1;
              state_d      = ST_WAIT_OUT;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_IN: begin
        if (bus.cin_valid) begin
          dwe_d     = 1'b1;
          dwa_d     = in_addr_q;
          dwd_d     = bus.cin;
          cin_ack_d = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_WAIT_OUT: begin
        if (bus.cout_ack) begin
          cout_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

`ifdef STAGE_EXECUTE_OUT_FIFO_EN
    cout_d       = fifo_head_d;
    cout_valid_d = fifo_nonempty_d;
`endif
  end

  // Every write, from INC/DEC or IN, enters the history as its newest entry.
  always_comb begin
    byp0_valid_d = byp0_valid_q;
    byp0_addr_d  = byp0_addr_q;
    byp0_data_d  = byp0_data_q;
    byp1_valid_d = byp1_valid_q;
    byp1_addr_d  = byp1_addr_q;
    byp1_data_d  = byp1_data_q;
    if (dwe_d) begin
      byp1_valid_d = byp0_valid_q;
      byp1_addr_d  = byp0_addr_q;
      byp1_data_d  = byp0_data_q;
      byp0_valid_d = 1'b1;
      byp0_addr_d  = dwa_d;
      byp0_data_d  = dwd_d;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      dwe_q          <= 1'b0;
      dwa_q          <= '0;
      dwd_q          <= '0;
      cout_q         <= '0;
      cout_valid_q   <= 1'b0;
      cin_ack_q      <= 1'b0;
      branch_q       <= 1'b0;
      branch_taken_q <= 1'b0;
      in_addr_q      <= '0;
      byp0_valid_q   <= 1'b0;
      byp0_addr_q    <= '0;
      byp0_data_q    <= '0;
      byp1_valid_q   <= 1'b0;
      byp1_addr_q    <= '0;
      byp1_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      dwe_q          <= dwe_d;
      dwa_q          <= dwa_d;
      dwd_q          <= dwd_d;
      cout_q         <= cout_d;
      cout_valid_q   <= cout_valid_d;
      cin_ack_q      <= cin_ack_d;
      branch_q       <= branch_d;
      branch_taken_q <= branch_taken_d;
      in_addr_q      <= in_addr_d;
      byp0_valid_q   <= byp0_valid_d;
      byp0_addr_q    <= byp0_addr_d;
      byp0_data_q    <= byp0_data_d;
      byp1_valid_q   <= byp1_valid_d;
      byp1_addr_q    <= byp1_addr_d;
      byp1_data_q    <= byp1_data_d;
    end
  end

`ifdef STAGE_EXECUTE_OUT_FIFO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= '0;
      end
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ack          = ack_c;
  assign bus.dwe          = dwe_q;
  assign bus.dwa          = dwa_q;
  assign bus.dwd          = dwd_q;
  assign bus.cout         = cout_q;
  assign bus.cout_valid   = cout_valid_q;
  assign bus.cin_ack      = cin_ack_q;
  assign bus.branch       = branch_q;
  assign bus.branch_taken = branch_taken_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_stage_execute.sv
// ---------------------------------------------------------------------------
// tb_stage_execute
//
// Self-checking bench for stage_execute: a table of single-operation
// vectors, hand-written multi-cycle sequences (reset during an IN wait,
// back-to-back RAW, IN wait, OUT handshake / FIFO fill and drain) and a
// randomized run checked against a cell-array reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef OPCODE_MSB
`define OPCODE_MSB   7
`endif
`ifndef OP_INCDP
`define OP_INCDP     0
`define OP_DECDP     1
`define OP_INC       2
`define OP_DEC       3
`define OP_OUT       4
`define OP_IN        5
`define OP_LOOPBEGIN 6
`define OP_LOOPEND   7
`endif

module tb_stage_execute;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int EW = 1 + AW + DW + 1 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  logic [1:0] run_code;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  stage_execute_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  stage_execute #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.drdy_in      = 1'b0;
    bus.operation_in = '0;
    bus.a_in         = '0;
    bus.da_in        = '0;
  endtask

  task automatic present(input logic drdy, input int op_bit,
                         input logic [DW-1:0] a, input logic [AW-1:0] da);
    bus.operation_in = '0;
    if (op_bit >= 0) bus.operation_in[op_bit] = 1'b1;
    bus.drdy_in = drdy;
    bus.a_in    = a;
    bus.da_in   = da;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_out(input logic we, input logic [AW-1:0] wa,
                                             input logic [DW-1:0] wd, input logic br,
                                             input logic tk);
    logic [AW-1:0] a_m;
    logic [DW-1:0] d_m;
    a_m = we ? wa : {AW{1'b0}};
    d_m = we ? wd : {DW{1'b0}};
    return {we, a_m, d_m, br, br & tk};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int            op;
    logic [DW-1:0] a;
    logic [AW-1:0] da;
    logic          e_we;
    logic [DW-1:0] e_wd;
    logic          e_br;
    logic          e_tk;
  } vec_t;

  vec_t vecs[11];

  // ---------------- reference model state ----------------
  logic [DW-1:0] mem_m[4];
  int            last_wr[4];

  initial begin
    vecs[0]  = '{`OP_INC,       8'hFF, 12'h100, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{`OP_DEC,       8'h00, 12'h101, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{`OP_INC,       8'h10, 12'h102, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3]  = '{`OP_DEC,       8'h80, 12'h103, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[4]  = '{`OP_LOOPBEGIN, 8'h00, 12'h104, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{`OP_LOOPBEGIN, 8'h05, 12'h105, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{`OP_LOOPEND,   8'h03, 12'h106, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{`OP_LOOPEND,   8'h00, 12'h107, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{`OP_INCDP,     8'h22, 12'h108, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{`OP_DECDP,     8'h33, 12'h109, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{-1,            8'h44, 12'h10A, 1'b0, 8'h00, 1'b0, 1'b0};

    idle_inputs();
    bus.cout_ack  = 1'b0;
    bus.cin       = '0;
    bus.cin_valid = 1'b0;

    // ---- reset state ----
    #12;
    chk("reset_ack", {31'd0, bus.ack}, 32'd0);
    chk("reset_dwe", {31'd0, bus.dwe}, 32'd0);
    chk("reset_cout_valid", {31'd0, bus.cout_valid}, 32'd0);
    chk("reset_branch", {31'd0, bus.branch}, 32'd0);
    rst_n = 1'b1;
    run_code = state_dbg;
    step();
    chk("run_ack", {31'd0, bus.ack}, 32'd1);

    // ---- vector table ----
    for (int i = 0; i < 11; i++) begin
      present(1'b1, vecs[i].op, vecs[i].a, vecs[i].da);
      #1;
      chk("vec_ack", {31'd0, bus.ack}, 32'd1);
      step();
      chk("vec_out", 32'(pack_out(bus.dwe, bus.dwa, bus.dwd, bus.branch, bus.branch_taken)),
          32'(pack_out(vecs[i].e_we, vecs[i].da, vecs[i].e_wd, vecs[i].e_br, vecs[i].e_tk)));
    end
    idle_inputs();
    step();

    // ---- reset during WAIT_IN, then INC at 5 ----
    present(1'b1, `OP_IN, 8'h00, 12'h009);
    #1;
    chk("rst_in_ack", {31'd0, bus.ack}, 32'd1);
    step();
    idle_inputs();
    #1;
    chk("rst_in_wait_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_in_state", {31'd0, state_dbg != run_code}, 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_mid_state", {30'd0, state_dbg}, {30'd0, run_code});
    #2;
    rst_n = 1'b1;
    step();
    bus.cin_valid = 1'b1;
    bus.cin       = 8'hEE;
    present(1'b1, `OP_INC, 8'h10, 12'h005);
    #1;
    chk("post_rst_ack", {31'd0, bus.ack}, 32'd1);
    chk("post_rst_nowrite", {31'd0, bus.dwe}, 32'd0);
    step();
    idle_inputs();
    bus.cin_valid = 1'b0;
    chk("post_rst_inc", 32'(pack_out(bus.dwe, bus.dwa, bus.dwd, 1'b0, 1'b0)),
        32'(pack_out(1'b1, 12'h005, 8'h11, 1'b0, 1'b0)));
    chk("post_rst_cin_ack", {31'd0, bus.cin_ack}, 32'd0);
    step();
    chk("post_rst_single", {31'd0, bus.dwe}, 32'd0);

    // ---- INC, INC, DEC back-to-back at 7 with stale a_in ----
    present(1'b1, `OP_INC, 8'h00, 12'h007);
    step();
    chk("b2b_w1", {23'd0, bus.dwe, bus.dwd}, {23'd0, 1'b1, 8'h01});
    present(1'b1, `OP_INC, 8'h00, 12'h007);
    step();
    chk("b2b_w2", {23'd0, bus.dwe, bus.dwd}, {23'd0, 1'b1, 8'h02});
    present(1'b1, `OP_DEC, 8'h00, 12'h007);
    step();
    chk("b2b_w3", {23'd0, bus.dwe, bus.dwd}, {23'd0, 1'b1, 8'h01});
    idle_inputs();
    step();
    // one-gap RAW at 7: last write was 0x01
    present(1'b1, `OP_INC, 8'h00, 12'h007);
    step();
    idle_inputs();
    chk("gap_raw", {23'd0, bus.dwe, bus.dwd}, {23'd0, 1'b1, 8'h02});
    step();

    // ---- IN with a 4-cycle wait ----
    present(1'b1, `OP_IN, 8'h00, 12'h020);
    #1;
    chk("in_accept", {31'd0, bus.ack}, 32'd1);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("in_wait_ack", {31'd0, bus.ack}, 32'd0);
      chk("in_wait_dwe", {30'd0, bus.dwe, bus.cin_ack}, 32'd0);
      step();
    end
    bus.cin_valid = 1'b1;
    bus.cin       = 8'h41;
    step();
    bus.cin_valid = 1'b0;
    chk("in_write", 32'(pack_out(bus.dwe, bus.dwa, bus.dwd, 1'b0, 1'b0)),
        32'(pack_out(1'b1, 12'h020, 8'h41, 1'b0, 1'b0)));
    chk("in_cin_ack", {31'd0, bus.cin_ack}, 32'd1);
    present(1'b1, `OP_INC, 8'h00, 12'h020);
    #1;
    chk("in_after_ack", {31'd0, bus.ack}, 32'd1);
    step();
    idle_inputs();
    chk("in_cin_ack_pulse", {31'd0, bus.cin_ack}, 32'd0);
    chk("in_then_inc", {23'd0, bus.dwe, bus.dwd}, {23'd0, 1'b1, 8'h42});
    step();

`ifdef STAGE_EXECUTE_OUT_FIFO_EN
    // ---- FIFO: fill with 5 OUTs, then drain ----
    begin
      int got;
      for (int i = 0; i < 5; i++) begin
        present(1'b1, `OP_OUT, 8'(8'h30 + i), 12'(12'h040 + i));
        #1;
        chk("fifo_fill_ack", {31'd0, bus.ack}, (i < 4) ? 32'd1 : 32'd0);
        if (i < 4) step();
      end
      step();
      chk("fifo_full_hold", {31'd0, bus.ack}, 32'd0);
      chk("fifo_head", {23'd0, bus.cout_valid, bus.cout}, {23'd0, 1'b1, 8'h30});
      bus.cout_ack = 1'b1;
      #1;
      chk("fifo_push_pop_ack", {31'd0, bus.ack}, 32'd1);
      got = 0;
      for (int c = 0; c < 12 && got < 5; c++) begin
        if (bus.cout_valid && bus.cout_ack) begin
          chk("fifo_order", {24'd0, bus.cout}, 32'(8'h30 + got));
          got++;
        end
        step();
        idle_inputs();
      end
      chk("fifo_count", got, 32'd5);
      bus.cout_ack = 1'b0;
      step();
      chk("fifo_empty", {31'd0, bus.cout_valid}, 32'd0);
    end
`else
    // ---- unbuffered OUT: stall until cout_ack each time ----
    for (int i = 0; i < 5; i++) begin
      present(1'b1, `OP_OUT, 8'(8'h30 + i), 12'(12'h040 + i));
      #1;
      chk("out_ack", {31'd0, bus.ack}, 32'd1);
      step();
      present(1'b1, `OP_OUT, 8'(8'h31 + i), 12'(12'h041 + i));
      #1;
      chk("out_stall", {31'd0, bus.ack}, 32'd0);
      chk("out_data", {23'd0, bus.cout_valid, bus.cout}, {23'd0, 1'b1, 8'(8'h30 + i)});
      step();
      chk("out_stall2", {31'd0, bus.ack}, 32'd0);
      bus.cout_ack = 1'b1;
      step();
      bus.cout_ack = 1'b0;
      chk("out_done", {31'd0, bus.cout_valid}, 32'd0);
    end
    idle_inputs();
    step();
`endif

    // ---- randomized run against the cell model ----
    for (int i = 0; i < 4; i++) begin
      mem_m[i]   = 8'($urandom);
      last_wr[i] = -10;
    end
    idle_inputs();
    step();
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int            k;
      int            ai;
      int            op;
      logic          drdy;
      logic [DW-1:0] a;
      logic [AW-1:0] addr;
      logic          e_we;
      logic [DW-1:0] e_wd;
      logic          e_br;
      logic          e_tk;
      if (exp_q.size() > 0) begin
        chk("rand_out", 32'(pack_out(bus.dwe, bus.dwa, bus.dwd, bus.branch, bus.branch_taken)),
            32'(exp_q.pop_front()));
      end
      k  = $urandom_range(0, 6);
      ai = $urandom_range(0, 3);
      case (k)
        0: op = `OP_INC;
        1: op = `OP_DEC;
        2: op = `OP_LOOPBEGIN;
        3: op = `OP_LOOPEND;
        4: op = `OP_INCDP;
        5: op = `OP_DECDP;
        default: op = -1;
      endcase
      drdy = ($urandom_range(0, 3) != 0);
      addr = 12'(12'h3F0 + ai);
      // RAM has not yet caught up with writes from the last two cycles
      a = ((cyc - last_wr[ai]) > 2) ? mem_m[ai] : 8'($urandom);
      e_we = 1'b0; e_wd = '0; e_br = 1'b0; e_tk = 1'b0;
      if (drdy) begin
        if (op == `OP_INC) begin
          e_we = 1'b1; e_wd = 8'((int'(mem_m[ai]) + 1) % 256);
        end else if (op == `OP_DEC) begin
          e_we = 1'b1; e_wd = 8'((int'(mem_m[ai]) + 255) % 256);
        end else if (op == `OP_LOOPBEGIN) begin
          e_br = 1'b1; e_tk = (mem_m[ai] == 0);
        end else if (op == `OP_LOOPEND) begin
          e_br = 1'b1; e_tk = (mem_m[ai] != 0);
        end
        if (e_we) begin
          mem_m[ai]   = e_wd;
          last_wr[ai] = cyc;
        end
      end
      exp_q.push_back(pack_out(e_we, addr, e_wd, e_br, e_tk));
      present(drdy, op, a, addr);
      #1;
      if (drdy) chk("rand_ack", {31'd0, bus.ack}, 32'd1);
      step();
    end
    idle_inputs();
    if (exp_q.size() > 0) begin
      chk("rand_last", 32'(pack_out(bus.dwe, bus.dwa, bus.dwd, bus.branch, bus.branch_taken)),
          32'(exp_q.pop_front()));
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_execute.md
# stage_execute

Execute/writeback stage of the bfcpu2 pipeline, directly downstream of the data-fetch stage. Consumes the one-hot operation, its valid flag and the fetched cell value, then performs the cell update (INC/DEC/IN), the character output (OUT) or the loop decision (LOOPBEGIN/LOOPEND). Writes results back to data RAM, forwards its own recent writes to cover read-after-write hazards, and drives `ack` upstream to stall the pipe during I/O waits.

## Interface
- A_WIDTH, 12, data RAM address width
- D_WIDTH, 8, cell width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- operation_in  in  `OPCODE_MSB+1`  one-hot opcode from dfetch
- drdy_in  in  1  operation_in/a_in/da_in valid this cycle
- a_in  in  D_WIDTH  fetched cell value
- da_in  in  A_WIDTH  address a_in was read from
- ack  out  1  operation accepted this cycle; 0 means upstream holds its outputs
- dwe  out  1  data RAM write enable
- dwa  out  A_WIDTH  write address
- dwd  out  D_WIDTH  write data
- cout  out  D_WIDTH  output character
- cout_valid  out  1  cout valid
- cout_ack  in  1  consumer takes cout when cout_valid && cout_ack
- cin  in  D_WIDTH  input character
- cin_valid  in  1  cin available
- cin_ack  out  1  one-cycle pulse: cin consumed
- branch  out  1  one-cycle pulse: loop decision valid
- branch_taken  out  1  qualified by branch: 1 = jump

## Operation
- Accept: drdy_in && ack at rising edge. Non-I/O and non-matching opcodes (INCDP/DECDP/none) are accepted and produce no effect.
- Operand select: 2-entry bypass (addr, value, valid), newest first. If da_in matches a valid entry, use that entry's value, otherwise a_in. Every write pushes {dwa,dwd}; the oldest entry drops.
- INC/DEC: dwd = operand ± 1, modulo 2^D_WIDTH (255+1 → 0, 0−1 → 255).
- LOOPBEGIN: branch=1, branch_taken = (operand == 0).
- LOOPEND: branch=1, branch_taken = (operand != 0).
- OUT: load operand onto cout.
- IN: write cin to the cell at da_in.
- FSM states:
  - RUN: ack = 1 unless the OUT path is blocked (see Configuration). Accepting IN goes to WAIT_IN. Accepting OUT in unbuffered mode goes to WAIT_OUT.
  - WAIT_IN: ack = 0. When cin_valid: dwe pulse, cin_ack pulse, return to RUN.
  - WAIT_OUT: ack = 0, cout_valid = 1. On cout_ack, return to RUN.
- Reset, asynchronous: FSM → RUN; bypass invalidated; output FIFO emptied. ack, dwe, dwa, dwd, cout, cout_valid, cin_ack, branch and branch_taken all 0. ack is held 0 while reset = 0. A pending IN/OUT aborted by reset is dropped and does not write.

## Timing
- All outputs except ack are registered. ack is combinational from state and FIFO level.
- INC/DEC/LOOP: dwe/dwa/dwd or branch/branch_taken are asserted for exactly one cycle, in the cycle after acceptance. Full throughput is one operation per cycle.
- IN: dwe and cin_ack are asserted in the cycle after the edge where cin_valid is sampled high in WAIT_IN. Minimum occupancy is 2 cycles.
- Bypass covers back-to-back and one-gap RAW on the same address. Writes 3 or more cycles earlier are read correctly from RAM.
- cin_valid and cout_ack are both sampled only in their own wait state (or FIFO head); there are no simultaneous-event conflicts.

## Configuration
- STAGE_EXECUTE_OUT_FIFO_EN defined:
  - OUT pushes into a 4-entry FIFO and does not leave RUN.
  - cout/cout_valid present the FIFO head; cout_ack pops it.
  - ack = 0 only when an OUT is presented with the FIFO full. Push and pop in the same cycle when full is accepted, and the count is unchanged.
- STAGE_EXECUTE_OUT_FIFO_EN undefined: no FIFO; every OUT enters WAIT_OUT, with cout valid one cycle after acceptance.

## Test plan
- Reset mid-WAIT_IN (cin_valid = 0), deassert, then present INC at da_in = 5 with a_in = 0x10 → no write for the aborted IN; dwe = 1, dwa = 5, dwd = 0x11 in the cycle after the INC is accepted.
- INC, INC, DEC back-to-back at address 7, a_in stale = 0x00 each time → writes 0x01, 0x02, 0x01 on consecutive cycles (bypass exercised).
- INC with a_in = 0xFF → dwd = 0x00. DEC with a_in = 0x00 → dwd = 0xFF.
- LOOPBEGIN operand 0 → branch = 1, branch_taken = 1. LOOPEND operand 3 → branch_taken = 1. LOOPEND operand 0 → branch_taken = 0.
- IN with cin_valid low 4 cycles then high with cin = 0x41 → ack = 0 for 4 cycles, then dwd = 0x41 with cin_ack = 1 one cycle after cin_valid.
- With FIFO_EN: 5 OUTs (0x30..0x34), cout_ack held 0 → ack drops on the 5th OUT. Then raise cout_ack → 0x30..0x34 emitted in order and the 5th OUT is accepted. Without FIFO_EN: ack = 0 after each OUT until cout_ack.
